// File: rtl/sprite_plotter_if.sv
// Pixel-write bus between the game controller, the sprite plotter and the VGA adapter.
// Hold start with valid inputs; a request is taken only on a rising edge where busy is low.
interface sprite_plotter_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7
);
    logic           start;
    logic [24:0]    sprite;
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic [2:0]     colour_in;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [2:0]     colour_out;
    logic           plot;
    logic           busy;
    logic           done;

    modport master (
        output start, sprite, x_in, y_in, colour_in,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, sprite, x_in, y_in, colour_in,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// Latches a 5x5 sprite request, erases the old footprint if the sprite moved,
// then writes all 25 pixels to the framebuffer one per cycle.
module sprite_plotter #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7
) (
    input  logic              clock,
    input  logic              resetn,
    sprite_plotter_if.slave   bus,
    output logic [1:0]        o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [24:0]    r_sprite;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [2:0]     r_colour;
    logic [X_W-1:0] r_prev_x;
    logic [Y_W-1:0] r_prev_y;
    logic           r_prev_valid;
    logic [2:0]     r_row;
    logic [2:0]     r_col;

    logic           w_last;
    logic           w_need_erase;
    logic [X_W-1:0] w_col_x;
    logic [Y_W-1:0] w_row_y;
    logic [4:0]     w_pix;
    logic [4:0]     w_bit_idx;

    assign w_col_x     = {{(X_W-3){1'b0}}, r_col};
    assign w_row_y     = {{(Y_W-3){1'b0}}, r_row};
    assign w_pix       = ({2'b00, r_row} << 2) + {2'b00, r_row} + {2'b00, r_col};
    assign w_bit_idx   = 5'd24 - w_pix;
    assign o_dbg_state = r_state;

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_last       = (r_row == 3'd4) && (r_col == 3'd4);
        w_need_erase = r_prev_valid && ((bus.x_in != r_prev_x) || (bus.y_in != r_prev_y));
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = w_need_erase ? S_ERASE : S_DRAW;
            S_ERASE: if (w_last) w_next_state = S_DRAW;
            S_DRAW:  if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Pixel outputs come straight from state and counters; coordinates wrap at the bus width.
    always_comb begin
        bus.plot       = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        bus.done       = 1'b0;
        bus.x_out      = '0;
        bus.y_out      = '0;
        bus.colour_out = BG_COLOUR;
        case (r_state)
            S_ERASE: begin
                bus.plot  = 1'b1;
                bus.x_out = r_prev_x + w_col_x;
                bus.y_out = r_prev_y + w_row_y;
            end
            S_DRAW: begin
                bus.plot       = 1'b1;
                bus.x_out      = r_x + w_col_x;
                bus.y_out      = r_y + w_row_y;
                bus.colour_out = r_sprite[w_bit_idx] ? r_colour : BG_COLOUR;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_sprite     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= BG_COLOUR;
            r_prev_x     <= '0;
            r_prev_y     <= '0;
            r_prev_valid <= 1'b0;
            r_row        <= '0;
            r_col        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sprite <= bus.sprite;
                        r_x      <= bus.x_in;
                        r_y      <= bus.y_in;
                        r_colour <= bus.colour_in;
                        r_row    <= '0;
                        r_col    <= '0;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (r_col == 3'd4) begin
                        r_col <= '0;
                        r_row <= (r_row == 3'd4) ? 3'd0 : r_row + 3'd1;
                    end else begin
                        r_col <= r_col + 3'd1;
                    end
                    if ((r_state == S_DRAW) && w_last) begin
                        r_prev_x     <= r_x;
                        r_prev_y     <= r_y;
                        r_prev_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// Scenario bench for sprite_plotter: pixel scoreboard plus per-scenario timing checks.
module tb_sprite_plotter;
    localparam int W = 18;

    logic       clock;
    logic       resetn;
    logic [1:0] dbg_state;

    sprite_plotter_if #(.X_W(8), .Y_W(7)) bus();

    sprite_plotter #(.BG_COLOUR(3'b000), .X_W(8), .Y_W(7)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [W-1:0] exp_q[$];
    logic [2:0]   fb [0:255][0:127];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         m_prev_valid = 1'b0;
    logic [7:0]   m_prev_x = '0;
    logic [6:0]   m_prev_y = '0;

    localparam logic [24:0] SPR_A   = 25'b0111011111110001111101110;
    localparam logic [24:0] SPR_B   = 25'b0111011100110001110001110;
    localparam logic [24:0] SPR_ONE = 25'h1FFFFFF;

    // Scoreboard: every plotted pixel must be the next expected write.
    always @(negedge clock) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (bus.plot === 1'b1) begin
            got = {bus.x_out, bus.y_out, bus.colour_out};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%b, required no write", bus.x_out, bus.y_out, bus.colour_out);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                             got[17:10], got[9:3], got[2:0], exp[17:10], exp[9:3], exp[2:0]);
                end
            end
            fb[bus.x_out][bus.y_out] = bus.colour_out;
        end
    end

    task automatic push_expect(input bit erase, input logic [24:0] spr, input logic [7:0] x,
                               input logic [6:0] y, input logic [2:0] col);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (erase) exp_q.push_back({8'(m_prev_x + c), 7'(m_prev_y + r), 3'b000});
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                exp_q.push_back({8'(x + c), 7'(y + r), spr[24 - (5 * r + c)] ? col : 3'b000});
    endtask

    task automatic drive_start(input logic [24:0] spr, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] col);
        bit erase;
        @(negedge clock);
        bus.start     = 1'b1;
        bus.sprite    = spr;
        bus.x_in      = x;
        bus.y_in      = y;
        bus.colour_in = col;
        erase = m_prev_valid && ((x != m_prev_x) || (y != m_prev_y));
        push_expect(erase, spr, x, y, col);
        @(posedge clock);
    endtask

    task automatic run_request(input logic [24:0] spr, input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] col, input bit scramble,
                               output int n_plot, output int first_plot, output int done_cyc,
                               output int n_busy);
        drive_start(spr, x, y, col);
        n_plot = 0; first_plot = 0; done_cyc = 0; n_busy = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clock);
            if (scramble) begin
                bus.start     = 1'b1;
                bus.sprite    = 25'($urandom);
                bus.x_in      = 8'($urandom_range(0, 255));
                bus.y_in      = 7'($urandom_range(0, 127));
                bus.colour_in = 3'($urandom_range(0, 7));
            end else begin
                bus.start = 1'b0;
            end
            if (bus.plot === 1'b1) begin
                n_plot++;
                if (first_plot == 0) first_plot = cyc;
            end
            if (bus.busy === 1'b1) n_busy++;
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
        bus.start = 1'b0;
        m_prev_valid = 1'b1;
        m_prev_x = x;
        m_prev_y = y;
    endtask

    task automatic check_timing(input string name, input int n_plot, input int first_plot,
                                input int done_cyc, input int n_busy, input int exp_plot);
        n_cmp++;
        if (n_plot !== exp_plot || first_plot !== 1) begin
            n_err++;
            $display("FAIL %s_plot: got %0d writes from cycle %0d, required %0d from cycle 1", name, n_plot, first_plot, exp_plot);
        end
        n_cmp++;
        if (done_cyc !== exp_plot + 1 || n_busy !== exp_plot + 1) begin
            n_err++;
            $display("FAIL %s_done: got done cycle %0d busy cycles %0d, required %0d and %0d", name, done_cyc, n_busy, exp_plot + 1, exp_plot + 1);
        end
        @(negedge clock);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.plot !== 1'b0 || bus.done !== 1'b0 || dbg_state !== 2'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_idle: got busy=%b plot=%b done=%b state=%0d pending=%0d, required 0 0 0 0 0",
                     name, bus.busy, bus.plot, bus.done, dbg_state, exp_q.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b state=%0d, required all zero",
                     bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out, dbg_state);
        end
        resetn = 1'b1;
    endtask

    task automatic test_draw_only();
        int np, fp, dc, nb;
        run_request(SPR_A, 8'd10, 7'd20, 3'b110, 1'b0, np, fp, dc, nb);
        check_timing("draw_only", np, fp, dc, nb, 25);
        n_cmp++;
        if (fb[10][20] !== 3'b000 || fb[11][20] !== 3'b110 || fb[13][22] !== 3'b000) begin
            n_err++;
            $display("FAIL draw_pixels: got (10,20)=%b (11,20)=%b (13,22)=%b, required 000 110 000", fb[10][20], fb[11][20], fb[13][22]);
        end
    endtask

    task automatic test_erase_draw();
        int np, fp, dc, nb;
        run_request(SPR_A, 8'd12, 7'd20, 3'b110, 1'b0, np, fp, dc, nb);
        check_timing("erase_draw", np, fp, dc, nb, 50);
        n_cmp++;
        if (fb[11][20] !== 3'b000 || fb[13][20] !== 3'b110) begin
            n_err++;
            $display("FAIL erase_pixels: got (11,20)=%b (13,20)=%b, required 000 110", fb[11][20], fb[13][20]);
        end
    endtask

    task automatic test_same_pos();
        int np, fp, dc, nb;
        run_request(SPR_B, 8'd12, 7'd20, 3'b101, 1'b0, np, fp, dc, nb);
        check_timing("same_pos", np, fp, dc, nb, 25);
        n_cmp++;
        if (fb[14][21] !== 3'b101 || fb[15][21] !== 3'b000) begin
            n_err++;
            $display("FAIL same_pos_pixels: got (14,21)=%b (15,21)=%b, required 101 000", fb[14][21], fb[15][21]);
        end
    endtask

    task automatic test_wrap();
        int np, fp, dc, nb;
        run_request(SPR_ONE, 8'd158, 7'd118, 3'b011, 1'b0, np, fp, dc, nb);
        check_timing("no_clip", np, fp, dc, nb, 50);
        n_cmp++;
        if (fb[162][118] !== 3'b011 || fb[158][122] !== 3'b011) begin
            n_err++;
            $display("FAIL no_clip_pixels: got (162,118)=%b (158,122)=%b, required 011 011", fb[162][118], fb[158][122]);
        end
        run_request(SPR_ONE, 8'd254, 7'd0, 3'b010, 1'b0, np, fp, dc, nb);
        check_timing("x_wrap", np, fp, dc, nb, 50);
        n_cmp++;
        if (fb[255][0] !== 3'b010 || fb[0][0] !== 3'b010 || fb[2][4] !== 3'b010) begin
            n_err++;
            $display("FAIL x_wrap_pixels: got (255,0)=%b (0,0)=%b (2,4)=%b, required 010 010 010", fb[255][0], fb[0][0], fb[2][4]);
        end
    endtask

    task automatic test_back_to_back();
        int np, fp, dc, nb;
        int n_busy_after;
        run_request(SPR_A, 8'd40, 7'd60, 3'b001, 1'b1, np, fp, dc, nb);
        check_timing("busy_starts", np, fp, dc, nb, 50);
        n_busy_after = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.busy !== 1'b0 || bus.plot !== 1'b0) n_busy_after++;
        end
        n_cmp++;
        if (n_busy_after !== 0) begin
            n_err++;
            $display("FAIL no_queued_start: got %0d active cycles after done, required 0", n_busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int np, fp, dc, nb;
        drive_start(SPR_B, 8'd40, 7'd60, 3'b100);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        resetn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got plot=%b busy=%b done=%b, required 0 0 0", bus.plot, bus.busy, bus.done);
        end
        exp_q.delete();
        m_prev_valid = 1'b0;
        resetn = 1'b1;
        run_request(SPR_A, 8'd70, 7'd80, 3'b110, 1'b0, np, fp, dc, nb);
        check_timing("after_reset", np, fp, dc, nb, 25);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 128; j++)
                fb[i][j] = 3'b111;
        bus.start     = 1'b0;
        bus.sprite    = '0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.colour_in = '0;
        test_reset();
        test_draw_only();
        test_erase_draw();
        test_same_pos();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
